axil_cmd_master: RTL and testbench

- Upstream driver for our AXI4-Lite register slaves, 4 x 32-bit regs at 0x0-0xC.
- Accepts single-beat register commands on a simple valid/ready command port.
- Runs exactly one AXI4-Lite read or write transaction per command.
- Returns write status or read data plus status on a valid/ready response port. Used by on-chip sequencers and by the bench as a deterministic bus driver.

---
 rtl/axil_cmd_master.sv | 205 ++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single-beat register commands into one AXI4-Lite
// read or write transaction each, and returns the status (and read data).
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   cmd_*              command in  (valid/ready, we, addr, wdata, wstrb)
//   rsp_*              response out (valid/ready, we, rdata, resp)
//   m_axil_*           AXI4-Lite master (AW, W, B, AR, R channels)
//
// Build option: define AXIL_CMD_MASTER_TIMEOUT_EN to add a watchdog that
// ends a stalled transaction after TIMEOUT_CYCLES cycles with SLVERR.
// Without it the master waits for the slave indefinitely.

module axil_cmd_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..65535");
    end

    logic [2:0] state;
    logic       aw_ok;
    logic       w_ok;
    logic       adv;
    logic       tmo;

    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    // A channel counts as done if already handshaken or handshaking now.
    always_comb begin
        aw_ok = !m_axil_awvalid || m_axil_awready;
        w_ok  = !m_axil_wvalid || m_axil_wready;
        adv   = 1'b0;
        unique case (state)
            S_WRITE: adv = aw_ok && w_ok;
            S_WRESP: adv = m_axil_bvalid;
            S_READ:  adv = m_axil_arready;
            S_RDATA: adv = m_axil_rvalid;
            default: adv = 1'b0;
        endcase
    end

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;
    logic        busy;

    assign busy = (state == S_WRITE) || (state == S_WRESP) ||
                  (state == S_READ)  || (state == S_RDATA);
    assign tmo  = busy && !adv && (tmo_cnt == TMO_LAST);

    // Restarts from zero on every entry into a waiting state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tmo_cnt <= '0;
        end else if (!busy || adv) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= S_IDLE;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_we         <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            m_axil_awaddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else if (tmo) begin
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b10;
            rsp_valid      <= 1'b1;
            state          <= S_RESP;
        end else begin
            unique case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rsp_we    <= cmd_we;
                        if (cmd_we) begin
                            m_axil_awaddr  <= cmd_addr;
                            m_axil_wdata   <= cmd_wdata;
                            m_axil_wstrb   <= cmd_wstrb;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= S_WRITE;
                        end else begin
                            m_axil_araddr  <= cmd_addr;
                            m_axil_arvalid <= 1'b1;
                            state          <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
                    if (adv) begin
                        m_axil_bready <= 1'b1;
                        state         <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (adv) begin
                        m_axil_bready <= 1'b0;
                        rsp_resp      <= m_axil_bresp;
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_READ: begin
                    if (adv) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state          <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (adv) begin
                        m_axil_rready <= 1'b0;
                        rsp_resp      <= m_axil_rresp;
                        rsp_rdata     <= m_axil_rdata;
                        rsp_valid     <= 1'b1;
                        state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed bench for axil_cmd_master with a small
// AXI4-Lite register slave whose per-channel delays are adjustable.

module tb_axil_cmd_master;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_we;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    always #5 aclk = ~aclk;

    axil_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // slave model knobs
    int         aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic       ar_never = 1'b0;
    logic [1:0] bresp_v = 2'b00;

    // slave model state
    logic [31:0] mem [4] = '{default: 32'h0};
    logic        aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    logic [3:0]  aw_a = '0, w_s = '0, cur_a, cur_s;
    logic [31:0] w_d = '0, cur_d, r_word = '0;
    logic        hs_aw, hs_w;
    int          n_aw = 0, n_w = 0;

    assign hs_aw = awvalid && awready;
    assign hs_w  = wvalid && wready;
    assign cur_a = hs_aw ? awaddr : aw_a;
    assign cur_d = hs_w ? wdata : w_d;
    assign cur_s = hs_w ? wstrb : w_s;

    always @(posedge aclk) begin
        if (!aresetn) begin
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_pend <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            if (hs_aw) begin
                aw_got <= 1'b1;
                aw_a   <= awaddr;
                n_aw   <= n_aw + 1;
            end
            if (hs_w) begin
                w_got <= 1'b1;
                w_d   <= wdata;
                w_s   <= wstrb;
                n_w   <= n_w + 1;
            end
            if ((aw_got || hs_aw) && (w_got || hs_w)) begin
                for (int i = 0; i < 4; i++)
                    if (cur_s[i]) mem[cur_a[3:2]][8*i +: 8] <= cur_d[8*i +: 8];
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_pend <= 1'b1;
            end
            if (bvalid && bready) b_pend <= 1'b0;
            if (arvalid && arready) begin
                r_pend <= 1'b1;
                r_word <= mem[araddr[3:2]];
            end
            if (rvalid && rready) r_pend <= 1'b0;
        end
    end

    // slave inputs change only on the falling edge
    initial begin
        int aw_c, w_c, b_c, ar_c, r_c;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
            end else begin
                if (awvalid) begin awready = (aw_c >= aw_dly); aw_c++; end
                else begin awready = 0; aw_c = 0; end
                if (wvalid) begin wready = (w_c >= w_dly); w_c++; end
                else begin wready = 0; w_c = 0; end
                if (b_pend) begin
                    bvalid = (b_c >= b_dly); bresp = bresp_v; b_c++;
                end else begin bvalid = 0; b_c = 0; end
                if (arvalid && !ar_never) begin
                    arready = (ar_c >= ar_dly); ar_c++;
                end else begin arready = 0; ar_c = 0; end
                if (r_pend) begin
                    rvalid = (r_c >= r_dly); rdata = r_word; rresp = 2'b00; r_c++;
                end else begin rvalid = 0; r_c = 0; end
            end
        end
    end

    task automatic do_cmd(input logic we, input logic [3:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        int n;
        @(negedge aclk);
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge aclk); n++; end
        chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(negedge aclk);
        cmd_valid = 0;
    endtask

    task automatic get_rsp(output logic we, output logic [31:0] d,
                           output logic [1:0] r);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin @(negedge aclk); n++; end
        chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
        we = rsp_we; d = rsp_rdata; r = rsp_resp;
        rsp_ready = 1;
        @(negedge aclk);
        rsp_ready = 0;
    endtask

    logic        g_we;
    logic [31:0] g_d;
    logic [1:0]  g_r;
    int          base_aw, base_w, cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        repeat (3) @(negedge aclk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        aresetn = 1;
        @(negedge aclk);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // basic write then read-back
        do_cmd(1, 4'h4, 32'hDEADBEEF, 4'hF);
        chk("t1_awvalid", {31'd0, awvalid}, 32'd1);
        chk("t1_awaddr", {28'd0, awaddr}, 32'h4);
        chk("t1_wdata", wdata, 32'hDEADBEEF);
        chk("t1_wstrb", {28'd0, wstrb}, 32'hF);
        chk("t1_prot", {26'd0, awprot, arprot}, 32'd0);
        get_rsp(g_we, g_d, g_r);
        chk("t1_rsp_we", {31'd0, g_we}, 32'd1);
        chk("t1_rsp_resp", {30'd0, g_r}, 32'd0);
        chk("t1_rsp_rdata", g_d, 32'd0);
        do_cmd(0, 4'h4, 32'h0, 4'h0);
        get_rsp(g_we, g_d, g_r);
        chk("t1_rd_we", {31'd0, g_we}, 32'd0);
        chk("t1_rd_data", g_d, 32'hDEADBEEF);

        // W completes three cycles before AW
        base_aw = n_aw; base_w = n_w;
        aw_dly = 3;
        do_cmd(1, 4'h0, 32'h12345678, 4'hF);
        @(negedge aclk);
        chk("t2_wvalid_drop", {31'd0, wvalid}, 32'd0);
        chk("t2_awvalid_hold", {31'd0, awvalid}, 32'd1);
        chk("t2_awaddr_hold", {28'd0, awaddr}, 32'h0);
        get_rsp(g_we, g_d, g_r);
        aw_dly = 0;
        chk("t2_n_aw", n_aw - base_aw, 32'd1);
        chk("t2_n_w", n_w - base_w, 32'd1);
        repeat (3) @(negedge aclk);
        chk("t2_single_rsp", {31'd0, rsp_valid}, 32'd0);

        // partial strobes
        do_cmd(1, 4'hC, 32'h11223344, 4'h5);
        get_rsp(g_we, g_d, g_r);
        do_cmd(0, 4'hC, 32'h0, 4'h0);
        get_rsp(g_we, g_d, g_r);
        chk("strb_rd", g_d, 32'h00220044);

        // delayed rvalid and held-off response
        do_cmd(1, 4'h8, 32'hCAFEF00D, 4'hF);
        get_rsp(g_we, g_d, g_r);
        r_dly = 5;
        do_cmd(0, 4'h8, 32'h0, 4'h0);
        chk("t3_araddr", {28'd0, araddr}, 32'h8);
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin @(negedge aclk); cnt++; end
        r_dly = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t3_hold_data", rsp_rdata, 32'hCAFEF00D);
            chk("t3_cmd_ready_lo", {31'd0, cmd_ready}, 32'd0);
            @(negedge aclk);
        end
        rsp_ready = 1;
        @(negedge aclk);
        rsp_ready = 0;
        chk("t3_cmd_ready_hi", {31'd0, cmd_ready}, 32'd1);
        chk("t3_rsp_clear", {31'd0, rsp_valid}, 32'd0);

        // SLVERR on B passes straight through
        bresp_v = 2'b10;
        do_cmd(1, 4'h0, 32'h55, 4'hF);
        get_rsp(g_we, g_d, g_r);
        bresp_v = 2'b00;
        chk("t4_bresp", {30'd0, g_r}, 32'h2);
        chk("t4_idle", {31'd0, cmd_ready}, 32'd1);

        // reset while AW/W outstanding
        aw_dly = 50; w_dly = 50;
        do_cmd(1, 4'h4, 32'hA5A5A5A5, 4'hF);
        chk("t5_awvalid_pre", {31'd0, awvalid}, 32'd1);
        #2 aresetn = 0;
        #1;
        chk("t5_awvalid", {31'd0, awvalid}, 32'd0);
        chk("t5_wvalid", {31'd0, wvalid}, 32'd0);
        chk("t5_awaddr", {28'd0, awaddr}, 32'd0);
        chk("t5_wdata", wdata, 32'd0);
        chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        aw_dly = 0; w_dly = 0;
        repeat (2) @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        chk("t5_ready_after", {31'd0, cmd_ready}, 32'd1);
        repeat (5) @(negedge aclk);
        chk("t5_no_stale_rsp", {31'd0, rsp_valid}, 32'd0);
        do_cmd(0, 4'h4, 32'h0, 4'h0);
        get_rsp(g_we, g_d, g_r);
        chk("t5_recover_rd", g_d, 32'hDEADBEEF);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
        // arready never comes; watchdog ends the read
        ar_never = 1;
        do_cmd(0, 4'h8, 32'h0, 4'h0);
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin @(negedge aclk); cnt++; end
        chk("t6_tmo_cycles", cnt, 32'd16);
        chk("t6_arvalid", {31'd0, arvalid}, 32'd0);
        chk("t6_rresp", {30'd0, rsp_resp}, 32'h2);
        chk("t6_rdata", rsp_rdata, 32'd0);
        get_rsp(g_we, g_d, g_r);
        ar_never = 0;
`else
        // no watchdog: a long stall still completes normally
        r_dly = 40;
        do_cmd(0, 4'h8, 32'h0, 4'h0);
        get_rsp(g_we, g_d, g_r);
        r_dly = 0;
        chk("t6_long_rresp", {30'd0, g_r}, 32'd0);
        chk("t6_long_rdata", g_d, 32'hCAFEF00D);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
